// File: rtl/matrix_mem_pkg.sv
// matrix_mem_pkg: opcodes, parameter-register map and FSM encoding
// shared by the matrix scratchpad responder and its users.
package matrix_mem_pkg;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  localparam int unsigned PARAM_WIDTH_A  = 1;
  localparam int unsigned PARAM_HEIGHT_A = 2;
  localparam int unsigned PARAM_WIDTH_B  = 3;
  localparam int unsigned PARAM_HEIGHT_B = 4;
  localparam int unsigned OPERAND_BASE   = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } mm_state_e;

  // 2'b10 is reserved and behaves like no request
  function automatic logic is_req(input logic [1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

endpackage

// File: rtl/matrix_mem_responder_if.sv
// matrix_mem_responder_if: accelerator memory request/response bus
// between a matrix engine (master) and the scratchpad (slave).
interface matrix_mem_responder_if;

  logic [1:0]  mem_operation;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        mem_opdone;

  modport master (
    output mem_operation,
    output addr_i,
    output data_i,
    input  data_o,
    input  mem_opdone
  );

  modport slave (
    input  mem_operation,
    input  addr_i,
    input  data_i,
    output data_o,
    output mem_opdone
  );

endinterface

// File: rtl/matrix_mem_array.sv
// matrix_mem_array: dual-port synchronous word RAM, responder port A
// and host port B, registered reads, contents never reset.
module matrix_mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_a_re,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [31:0]   i_a_wdata,
  output logic [31:0]   o_a_rdata,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [31:0]   i_b_wdata,
  output logic [31:0]   o_b_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;

  // Port A and port B writes are mutually exclusive by construction upstream
  always_ff @(posedge clk) begin
    if (i_a_we) begin
      r_mem[i_a_addr] <= i_a_wdata;
    end
    if (i_b_we) begin
      r_mem[i_b_addr] <= i_b_wdata;
    end
    if (i_a_re) begin
      r_a_rdata <= r_mem[i_a_addr];
    end
    r_b_rdata <= r_mem[i_b_addr];
  end

  assign o_a_rdata = r_a_rdata;
  assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/matrix_mem_responder.sv
// matrix_mem_responder: latency-programmable scratchpad responder with host port.
// Define MATRIX_MEM_ACCESS_COUNT_EN to add rd_count/wr_count access counters.
module matrix_mem_responder
  import matrix_mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_mem_responder_if.slave bus,
  output logic                  error,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_addr,
  input  logic [31:0]           host_wdata,
  output logic [31:0]           host_rdata,
  output logic                  host_ready
`ifdef MATRIX_MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);

  mm_state_e     r_state;
  logic [3:0]    r_cnt;
  logic [1:0]    r_op;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_oor;
  logic [31:0]   r_data_o;
  logic          r_error;
  logic          r_hvld;

  logic          w_idle;
  logic          w_req;
  logic          w_go_resp;
  logic          w_respond;
  logic          w_rd;
  logic          w_wr_hit;
  logic          w_host_we;
  logic [AW-1:0] w_a_addr;
  logic [31:0]   w_a_rdata;
  logic [31:0]   w_b_rdata;
  logic [31:0]   w_rd_data;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_req     = w_idle && is_req(bus.mem_operation);
  assign w_respond = (r_state == ST_RESPOND);
  assign w_rd      = w_respond && (r_op == MEM_OP_READ);
  assign w_wr_hit  = w_respond && (r_op == MEM_OP_WRITE) && !r_oor;

  // The RAM read is launched on the edge entering RESPOND
  assign w_go_resp = (w_req && (LATENCY == 1)) ||
                     ((r_state == ST_WAIT) && (r_cnt == 4'd1));

  assign w_a_addr  = w_idle ? bus.addr_i[AW-1:0] : r_addr;
  assign w_host_we = host_we && host_ready;

  matrix_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .i_a_re    (w_go_resp),
    .i_a_we    (w_wr_hit),
    .i_a_addr  (w_a_addr),
    .i_a_wdata (r_wdata),
    .o_a_rdata (w_a_rdata),
    .i_b_we    (w_host_we),
    .i_b_addr  (host_addr),
    .i_b_wdata (host_wdata),
    .o_b_rdata (w_b_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= MEM_OP_NONE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_oor   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_op    <= bus.mem_operation;
            r_addr  <= bus.addr_i[AW-1:0];
            r_wdata <= bus.data_i;
            r_oor   <= (bus.addr_i >= 32'(DEPTH));
            r_cnt   <= 4'(LATENCY - 1);
            if (LATENCY == 1) begin
              r_state <= ST_RESPOND;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_rd_data = r_oor ? 32'd0 : w_a_rdata;

  // data_o shows RAM data while responding, then holds the last read value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_o <= '0;
      r_error  <= 1'b0;
      r_hvld   <= 1'b0;
    end else begin
      r_hvld <= 1'b1;
      if (w_rd) begin
        r_data_o <= w_rd_data;
      end
      if (w_respond && r_oor) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.data_o     = w_rd ? w_rd_data : r_data_o;
  assign bus.mem_opdone = w_respond;
  assign error          = r_error;
  assign host_rdata     = r_hvld ? w_b_rdata : 32'd0;
  assign host_ready     = w_idle && (bus.mem_operation == MEM_OP_NONE);

`ifdef MATRIX_MEM_ACCESS_COUNT_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd && !r_oor) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (w_wr_hit) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_matrix_mem_responder.sv
// tb_matrix_mem_responder: directed self-checking bench for the
// scratchpad responder (DEPTH=256, LATENCY=2).
module tb_matrix_mem_responder;
  import matrix_mem_pkg::*;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int AW      = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          error;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [31:0]   host_wdata = '0;
  logic [31:0]   host_rdata;
  logic          host_ready;
`ifdef MATRIX_MEM_ACCESS_COUNT_EN
  logic [31:0]   rd_count;
  logic [31:0]   wr_count;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  matrix_mem_responder_if bus ();

  matrix_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .error      (error),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ready (host_ready)
`ifdef MATRIX_MEM_ACCESS_COUNT_EN
    ,
    .rd_count   (rd_count),
    .wr_count   (wr_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  task automatic host_rd(input logic [AW-1:0] a, output logic [31:0] q);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    q = host_rdata;
  endtask

  // a2 is driven on addr_i once the request has been accepted
  task automatic req(input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] a2, input logic [31:0] d,
                     output logic [31:0] q, output int lat);
    @(negedge clk);
    bus.mem_operation = op;
    bus.addr_i        = a;
    bus.data_i        = d;
    lat = 99;
    q   = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.mem_operation = MEM_OP_NONE;
        bus.addr_i        = a2;
      end
      if (bus.mem_opdone) begin
        lat = n;
        q   = bus.data_o;
        break;
      end
    end
    @(negedge clk);
    chk("opdone_pulse", {31'd0, bus.mem_opdone}, 32'd0);
  endtask

  logic [31:0] q;
  int          lat;
  logic        seen;

  initial begin
    bus.mem_operation = MEM_OP_NONE;
    bus.addr_i        = '0;
    bus.data_i        = '0;
    repeat (3) @(negedge clk);
    chk("rst_opdone", {31'd0, bus.mem_opdone}, 32'd0);
    chk("rst_data_o", bus.data_o, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_host_rdata", host_rdata, 32'd0);
    chk("rst_host_ready", {31'd0, host_ready}, 32'd1);
    reset = 1'b1;

    host_wr(8'd1, 32'd3);
    host_wr(8'd2, 32'd3);
    host_wr(8'd3, 32'd2);
    host_wr(8'd4, 32'd2);
    host_wr(8'd5, 32'h55);
    host_wr(8'd7, 32'h77);
    host_wr(8'd10, 32'h1010);
    host_wr(8'd11, 32'h1111);
    host_wr(8'd20, 32'h2020);

    req(MEM_OP_READ, 32'd1, 32'd1, 32'd0, q, lat);
    chk("rd1_latency", 32'(lat), 32'd2);
    chk("rd1_data", q, 32'd3);
    req(MEM_OP_READ, 32'd2, 32'd2, 32'd0, q, lat);
    chk("rd2_data", q, 32'd3);
    req(MEM_OP_READ, 32'd3, 32'd3, 32'd0, q, lat);
    chk("rd3_data", q, 32'd2);
    req(MEM_OP_READ, 32'd4, 32'd4, 32'd0, q, lat);
    chk("rd4_data", q, 32'd2);

    req(MEM_OP_WRITE, 32'd40, 32'd40, 32'hDEADBEEF, q, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_data_o_held", q, 32'd2);
    host_rd(8'd40, q);
    chk("wr_host_readback", q, 32'hDEADBEEF);

    req(MEM_OP_READ, 32'(DEPTH + 5), 32'(DEPTH + 5), 32'd0, q, lat);
    chk("oor_latency", 32'(lat), 32'd2);
    chk("oor_data", q, 32'd0);
    chk("oor_error", {31'd0, error}, 32'd1);

    req(MEM_OP_READ, 32'd10, 32'd11, 32'd0, q, lat);
    chk("midwait_data", q, 32'h1010);
    req(MEM_OP_READ, 32'd11, 32'd11, 32'd0, q, lat);
    chk("next_data", q, 32'h1111);
    chk("error_sticky", {31'd0, error}, 32'd1);

    @(negedge clk);
    bus.mem_operation = MEM_OP_WRITE;
    bus.addr_i        = 32'd7;
    bus.data_i        = 32'hBAD;
    @(negedge clk);
    bus.mem_operation = MEM_OP_NONE;
    reset = 1'b0;
    #1;
    chk("abort_opdone", {31'd0, bus.mem_opdone}, 32'd0);
    chk("abort_data_o", bus.data_o, 32'd0);
    chk("abort_error", {31'd0, error}, 32'd0);
    chk("abort_host_rdata", host_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_opdone) seen = 1'b1;
    end
    chk("abort_no_opdone", {31'd0, seen}, 32'd0);
    host_rd(8'd7, q);
    chk("abort_mem7", q, 32'h77);
`ifdef MATRIX_MEM_ACCESS_COUNT_EN
    chk("rst_rd_count", rd_count, 32'd0);
    chk("rst_wr_count", wr_count, 32'd0);
`endif

    @(negedge clk);
    bus.mem_operation = MEM_OP_READ;
    bus.addr_i        = 32'd5;
    @(negedge clk);
    bus.mem_operation = MEM_OP_NONE;
    host_we    = 1'b1;
    host_addr  = 8'd20;
    host_wdata = 32'hABCD;
    chk("wait_host_ready", {31'd0, host_ready}, 32'd0);
    @(negedge clk);
    host_we = 1'b0;
    chk("hostwait_opdone", {31'd0, bus.mem_opdone}, 32'd1);
    chk("hostwait_data", bus.data_o, 32'h55);
    @(negedge clk);
    host_rd(8'd20, q);
    chk("host_drop", q, 32'h2020);
    host_wr(8'd20, 32'hABCD);
    host_rd(8'd20, q);
    chk("host_idle_wr", q, 32'hABCD);

    req(MEM_OP_READ, 32'd1, 32'd1, 32'd0, q, lat);
    req(MEM_OP_READ, 32'd2, 32'd2, 32'd0, q, lat);
    req(MEM_OP_WRITE, 32'd41, 32'd41, 32'h4141, q, lat);
    host_rd(8'd41, q);
    chk("wr41_readback", q, 32'h4141);
`ifdef MATRIX_MEM_ACCESS_COUNT_EN
    chk("rd_count", rd_count, 32'd3);
    chk("wr_count", wr_count, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_mem_responder.md
Name: matrix_mem_responder

Overview:
Word-addressed scratchpad memory that acts as the responder on the accelerator memory interface (mem_operation / addr / data / mem_opdone). It serves read (01) and write (11) requests from matrix engines, such as the convolution and multiply FSMs, with a programmable access latency. A host load port preloads parameters and operand matrices and reads back results.

Parameters:
DEPTH, 256, number of 32-bit words; valid addresses 0..DEPTH-1
LATENCY, 2, cycles from request accept to mem_opdone pulse; legal range 1..15
AW, $clog2(DEPTH), internal address width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low (0 = reset)
mem_operation  in  2  request from initiator: 00 none, 01 read, 11 write, 10 reserved (treated as none)
addr_i  in  32  word address from initiator
data_i  in  32  write data from initiator
data_o  out  32  read data to initiator, valid while mem_opdone=1
mem_opdone  out  1  one-cycle completion pulse
error  out  1  sticky out-of-range flag
host_we  in  1  host write strobe
host_addr  in  AW  host word address
host_wdata  in  32  host write data
host_rdata  out  32  host read data, registered, 1-cycle latency from host_addr
host_ready  out  1  1 when responder is IDLE and mem_operation==00

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, data_o=0, mem_opdone=0, error=0, host_rdata=0, latency counter=0. Memory contents are not cleared. Reset mid-request aborts the request; no opdone and no write.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE: if mem_operation is 01 or 11, latch op, addr_i and data_i; load counter with LATENCY-1; go to WAIT (or straight to RESPOND when LATENCY=1).
- WAIT: decrement counter; at 0 go to RESPOND. Request inputs are ignored, so a changed addr_i mid-wait has no effect on this access.
- RESPOND: assert mem_opdone for exactly this cycle.
  - Read: data_o = mem[latched addr].
  - Write: mem[latched addr] <= latched data on this edge; data_o is held.
  - Return to IDLE next cycle.
- Back-to-back: the initiator updates the address on the opdone edge, and the responder samples it in the following IDLE cycle. A held mem_operation with a new address is a new request. Minimum request spacing is LATENCY+1 cycles.
- Out-of-range (latched addr >= DEPTH): opdone still pulses at normal latency, read data_o=0, write discarded, error set. error stays set until reset.
- Address is word-granular: only addr[AW-1:0] is used after the range check.
- Host port:
  - A host write takes effect only when host_ready=1; writes while host_ready=0 are dropped.
  - Host reads are always allowed.
  - On a same-cycle collision, responder RESPOND-write and host write to the same address never coexist because host_ready=0 in RESPOND.
- data_o is held between responses (it is not cleared).

Optional Feature:
MATRIX_MEM_ACCESS_COUNT_EN
- Defined: adds outputs rd_count[31:0] and wr_count[31:0]. Each increments on every RESPOND cycle of its type, in-range accesses only, and wraps at 2^32. Both reset to 0.
- Undefined: the ports and counters are absent, with no other change.

Decomposition:
- Shared package matrix_mem_pkg holds:
  - opcode constants MEM_OP_NONE=2'b00, MEM_OP_READ=2'b01, MEM_OP_WRITE=2'b11
  - parameter-register offsets 1..4 (width A, height A, width B, height B)
  - operand base offset 6
  - the responder state enum
- One sub-module is natural: matrix_mem_array, a dual-port synchronous RAM with one responder port and one host port, no reset.

Test Plan:
1. LATENCY=2: host preloads mem[1..4]=3,3,2,2, then the initiator reads addr 1 → mem_opdone high exactly 2 cycles after accept, data_o=3. Sequential reads 2,3,4 return 3,2,2.
2. Write: mem_operation=11, addr=40, data=0xDEADBEEF → opdone after LATENCY. A host read of 40 then gives 0xDEADBEEF.
3. Out of range: read addr=DEPTH+5 → opdone pulses, data_o=0, error=1 and stays 1 through later good accesses.
4. Mid-wait address change: addr_i changes from 10 to 11 during WAIT → returned data = mem[10]. The next request then returns mem[11].
5. Reset pulse (reset=0) during WAIT of a write to addr 7 → no opdone, mem[7] unchanged, all outputs at reset values.
6. Host write with host_ready=0, issued during WAIT to addr 20 → mem[20] unchanged. The same write issued in IDLE succeeds. With MATRIX_MEM_ACCESS_COUNT_EN defined, after 3 reads and 1 write: rd_count=3, wr_count=1.
